// File: rtl/ofm_wr_scheduler_pkg.sv
// Shared types and default sizes for the OFM write-port scheduler.
package ofm_sched_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        ARB   = 2'b01,
        BURST = 2'b10,
        DONE  = 2'b11
    } state_t;

    localparam int SCHED_BURST_LEN = 4;
    localparam int SCHED_ADDR_W    = 32;

endpackage

// File: rtl/ofm_wr_scheduler_if.sv
// Request/grant and RAM write bus between the OFM controllers and the scheduler.
interface ofm_wr_scheduler_if
    import ofm_sched_pkg::*;
#(
    parameter int NUM_REQ   = 4,
    parameter int BURST_LEN = SCHED_BURST_LEN,
    parameter int ADDR_W    = SCHED_ADDR_W
);
    localparam int SEL_W  = $clog2(NUM_REQ);
    localparam int BEAT_W = $clog2(BURST_LEN);

    logic                start;
    logic                abort;
    logic [ADDR_W-1:0]   cfg_base_addr;
    logic [ADDR_W-1:0]   cfg_total_words;
    logic [NUM_REQ-1:0]  req;
    logic [NUM_REQ-1:0]  gnt;
    logic [SEL_W-1:0]    wr_sel;
    logic [BEAT_W-1:0]   beat_idx;
    logic                wr_en;
    logic [ADDR_W-1:0]   wr_addr;
    logic                burst_last;
    logic                busy;
    logic                layer_done;

    modport master (
        output start, abort, cfg_base_addr, cfg_total_words, req,
        input  gnt, wr_sel, beat_idx, wr_en, wr_addr, burst_last, busy, layer_done
    );

    modport slave (
        input  start, abort, cfg_base_addr, cfg_total_words, req,
        output gnt, wr_sel, beat_idx, wr_en, wr_addr, burst_last, busy, layer_done
    );

endinterface

// File: rtl/ofm_wr_scheduler_rr_arbiter.sv
// Combinational round-robin pick: first set request after last_grant, wrapping.
module rr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int SEL_W   = $clog2(NUM_REQ)
)(
    input  logic [NUM_REQ-1:0] req,
    input  logic [SEL_W-1:0]   last_grant,
    output logic [NUM_REQ-1:0] onehot,
    output logic [SEL_W-1:0]   index,
    output logic               any_req
);
    int               w_pos;
    logic [SEL_W-1:0] w_try;
    logic             w_found;

    // Scan candidates starting just after the previous winner.
    always_comb begin
        w_pos   = 0;
        w_try   = {SEL_W{1'b0}};
        w_found = 1'b0;
        index   = {SEL_W{1'b0}};
        for (int i = 0; i < NUM_REQ; i++) begin
            w_pos = int'(last_grant) + 1 + i;
            if (w_pos >= NUM_REQ) begin
                w_pos = w_pos - NUM_REQ;
            end else begin
                w_pos = w_pos;
            end
            w_try = SEL_W'(w_pos);
            if (!w_found && req[w_try]) begin
                w_found = 1'b1;
                index   = w_try;
            end else begin
                w_found = w_found;
            end
        end
    end

    assign any_req = w_found;
    assign onehot  = w_found ? (NUM_REQ'(1) << index) : {NUM_REQ{1'b0}};

endmodule

// File: rtl/ofm_wr_scheduler.sv
// Round-robin owner of the next-layer RAM write port; bursts of BURST_LEN beats per grant.
module ofm_wr_scheduler
    import ofm_sched_pkg::*;
#(
    parameter int NUM_REQ   = 4,
    parameter int BURST_LEN = SCHED_BURST_LEN,
    parameter int ADDR_W    = SCHED_ADDR_W,
    parameter int SEL_W     = $clog2(NUM_REQ),
    parameter int BEAT_W    = $clog2(BURST_LEN)
)(
    input  logic               clk,
    input  logic               rst_n,
    ofm_wr_scheduler_if.slave  bus
);
    localparam logic [BEAT_W-1:0] BEAT_MAX = BEAT_W'(BURST_LEN - 1);
    localparam logic [SEL_W-1:0]  SEL_RST  = SEL_W'(NUM_REQ - 1);

    state_t              r_state,  w_state_nx;
    logic [ADDR_W-1:0]   r_base,   w_base_nx;
    logic [ADDR_W-1:0]   r_total,  w_total_nx;
    logic [ADDR_W-1:0]   r_cnt,    w_cnt_nx;
    logic [BEAT_W-1:0]   r_beat,   w_beat_nx;
    logic [NUM_REQ-1:0]  r_gnt,    w_gnt_nx;
    logic [SEL_W-1:0]    r_sel,    w_sel_nx;
    logic [SEL_W-1:0]    r_lastg,  w_lastg_nx;
    logic                r_wr_en,  w_wr_en_nx;
    logic [ADDR_W-1:0]   r_addr,   w_addr_nx;
    logic                r_last,   w_last_nx;
    logic                r_busy,   w_busy_nx;
    logic                r_done,   w_done_nx;

    logic [NUM_REQ-1:0]  w_arb_onehot;
    logic [SEL_W-1:0]    w_arb_idx;
    logic                w_arb_any;
    logic [ADDR_W-1:0]   w_cnt_inc;
    logic [ADDR_W-1:0]   w_total_m1;
    logic [BEAT_W-1:0]   w_beat_inc;

    rr_arbiter #(.NUM_REQ(NUM_REQ), .SEL_W(SEL_W)) u_arb (
        .req        (bus.req),
        .last_grant (r_lastg),
        .onehot     (w_arb_onehot),
        .index      (w_arb_idx),
        .any_req    (w_arb_any)
    );

    assign w_cnt_inc  = r_cnt + ADDR_W'(1);
    assign w_total_m1 = r_total - ADDR_W'(1);
    assign w_beat_inc = r_beat + BEAT_W'(1);

    // Next-state and next-output decode; outputs describe the beat of the following cycle.
    always_comb begin
        w_state_nx = r_state;
        w_base_nx  = r_base;
        w_total_nx = r_total;
        w_cnt_nx   = r_cnt;
        w_beat_nx  = r_beat;
        w_gnt_nx   = r_gnt;
        w_sel_nx   = r_sel;
        w_lastg_nx = r_lastg;
        w_wr_en_nx = r_wr_en;
        w_addr_nx  = r_addr;
        w_last_nx  = r_last;
        w_busy_nx  = r_busy;
        w_done_nx  = 1'b0;
        if (bus.abort) begin
            w_state_nx = IDLE;
            w_cnt_nx   = {ADDR_W{1'b0}};
            w_beat_nx  = {BEAT_W{1'b0}};
            w_gnt_nx   = {NUM_REQ{1'b0}};
            w_sel_nx   = {SEL_W{1'b0}};
            w_wr_en_nx = 1'b0;
            w_addr_nx  = {ADDR_W{1'b0}};
            w_last_nx  = 1'b0;
            w_busy_nx  = 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (bus.start) begin
                        w_base_nx  = bus.cfg_base_addr;
                        w_total_nx = bus.cfg_total_words;
                        w_cnt_nx   = {ADDR_W{1'b0}};
                        if (bus.cfg_total_words == {ADDR_W{1'b0}}) begin
                            w_state_nx = DONE;
                            w_done_nx  = 1'b1;
                            w_busy_nx  = 1'b0;
                        end else begin
                            w_state_nx = ARB;
                            w_busy_nx  = 1'b1;
                        end
                    end else begin
                        w_state_nx = IDLE;
                    end
                end
                ARB: begin
                    if (w_arb_any) begin
                        w_state_nx = BURST;
                        w_gnt_nx   = w_arb_onehot;
                        w_sel_nx   = w_arb_idx;
                        w_lastg_nx = w_arb_idx;
                        w_beat_nx  = {BEAT_W{1'b0}};
                        w_wr_en_nx = 1'b1;
                        w_addr_nx  = r_base + r_cnt;
                        w_last_nx  = (BEAT_MAX == {BEAT_W{1'b0}}) || (r_cnt == w_total_m1);
                    end else begin
                        w_gnt_nx   = {NUM_REQ{1'b0}};
                        w_wr_en_nx = 1'b0;
                    end
                end
                BURST: begin
                    w_cnt_nx = w_cnt_inc;
                    if (r_last) begin
                        w_gnt_nx   = {NUM_REQ{1'b0}};
                        w_sel_nx   = {SEL_W{1'b0}};
                        w_beat_nx  = {BEAT_W{1'b0}};
                        w_wr_en_nx = 1'b0;
                        w_addr_nx  = {ADDR_W{1'b0}};
                        w_last_nx  = 1'b0;
                        if (r_cnt == w_total_m1) begin
                            w_state_nx = DONE;
                            w_done_nx  = 1'b1;
                            w_busy_nx  = 1'b0;
                        end else begin
                            w_state_nx = ARB;
                        end
                    end else begin
                        w_beat_nx = w_beat_inc;
                        w_addr_nx = r_base + w_cnt_inc;
                        w_last_nx = (w_beat_inc == BEAT_MAX) || (w_cnt_inc == w_total_m1);
                    end
                end
                DONE: begin
                    w_state_nx = IDLE;
                end
                default: begin
                    w_state_nx = IDLE;
                    w_gnt_nx   = {NUM_REQ{1'b0}};
                    w_wr_en_nx = 1'b0;
                    w_last_nx  = 1'b0;
                    w_busy_nx  = 1'b0;
                end
            endcase
        end
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_base  <= {ADDR_W{1'b0}};
            r_total <= {ADDR_W{1'b0}};
            r_cnt   <= {ADDR_W{1'b0}};
            r_beat  <= {BEAT_W{1'b0}};
            r_gnt   <= {NUM_REQ{1'b0}};
            r_sel   <= {SEL_W{1'b0}};
            r_lastg <= SEL_RST;
            r_wr_en <= 1'b0;
            r_addr  <= {ADDR_W{1'b0}};
            r_last  <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nx;
            r_base  <= w_base_nx;
            r_total <= w_total_nx;
            r_cnt   <= w_cnt_nx;
            r_beat  <= w_beat_nx;
            r_gnt   <= w_gnt_nx;
            r_sel   <= w_sel_nx;
            r_lastg <= w_lastg_nx;
            r_wr_en <= w_wr_en_nx;
            r_addr  <= w_addr_nx;
            r_last  <= w_last_nx;
            r_busy  <= w_busy_nx;
            r_done  <= w_done_nx;
        end
    end

    assign bus.gnt        = r_gnt;
    assign bus.wr_sel     = r_sel;
    assign bus.beat_idx   = r_beat;
    assign bus.wr_en      = r_wr_en;
    assign bus.wr_addr    = r_addr;
    assign bus.burst_last = r_last;
    assign bus.busy       = r_busy;
    assign bus.layer_done = r_done;

endmodule

// File: tb/tb_ofm_wr_scheduler.sv
// Self-checking bench: layer table with a write scoreboard, plus hand-written abort/reset/sparse sequences.
module tb_ofm_wr_scheduler;

    typedef struct packed {
        logic [31:0] addr;
        logic [1:0]  sel;
        logic [1:0]  beat;
        logic        last;
    } exp_t;

    typedef struct {
        logic [31:0] base;
        logic [31:0] total;
        logic [3:0]  req;
        bit          spur;
        int          bursts;
    } vec_t;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_fail;
    int   m_lastg;
    exp_t sbq[$];
    vec_t vecs[6];

    ofm_wr_scheduler_if #(.NUM_REQ(4), .BURST_LEN(4), .ADDR_W(32)) bus ();

    ofm_wr_scheduler dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic push_exp(input logic [31:0] a, input int s, input int b, input bit l);
        exp_t e;
        e.addr = a;
        e.sel  = 2'(s);
        e.beat = 2'(b);
        e.last = l;
        sbq.push_back(e);
    endtask

    // Reference: round-robin over a constant request vector.
    task automatic model_layer(input logic [31:0] base, input logic [31:0] total, input logic [3:0] req);
        logic [31:0] cnt;
        int g;
        cnt = 32'd0;
        while (cnt < total && req != 4'b0000) begin
            g = -1;
            for (int i = 1; i <= 4; i++) begin
                if (g < 0 && req[(m_lastg + i) % 4]) g = (m_lastg + i) % 4;
            end
            m_lastg = g;
            for (int b = 0; b < 4 && cnt < total; b++) begin
                push_exp(base + cnt, g, b, (b == 3) || (cnt == total - 32'd1));
                cnt = cnt + 32'd1;
            end
        end
    endtask

    task automatic tick();
        exp_t e;
        @(posedge clk);
        @(negedge clk);
        if (bus.wr_en === 1'b1) begin
            if (sbq.size() == 0) begin
                chk("unexpected_write", 64'(bus.wr_en), 64'd0);
            end else begin
                e = sbq.pop_front();
                chk("wr_addr", 64'(bus.wr_addr), 64'(e.addr));
                chk("wr_sel", 64'(bus.wr_sel), 64'(e.sel));
                chk("gnt", 64'(bus.gnt), 64'(4'b0001 << e.sel));
                chk("beat_idx", 64'(bus.beat_idx), 64'(e.beat));
                chk("burst_last", 64'(bus.burst_last), 64'(e.last));
            end
        end else begin
            chk("idle_gnt", 64'(bus.gnt), 64'd0);
            chk("idle_burst_last", 64'(bus.burst_last), 64'd0);
        end
    endtask

    task automatic run_layer(input vec_t v);
        int cyc;
        int done_at;
        model_layer(v.base, v.total, v.req);
        bus.cfg_base_addr   = v.base;
        bus.cfg_total_words = v.total;
        bus.req             = v.req;
        bus.start           = 1'b1;
        tick();
        bus.start = 1'b0;
        cyc       = 1;
        done_at   = 0;
        while (done_at == 0 && cyc < 300) begin
            if (bus.layer_done === 1'b1) begin
                done_at = cyc;
            end else begin
                chk("busy_during_layer", 64'(bus.busy), 64'd1);
                if (v.spur && cyc == 3) begin
                    bus.start           = 1'b1;
                    bus.cfg_base_addr   = 32'hDEAD_0000;
                    bus.cfg_total_words = 32'd99;
                end else begin
                    bus.start = 1'b0;
                end
                tick();
                cyc++;
            end
        end
        bus.start = 1'b0;
        chk("done_cycle", 64'(done_at), 64'(1 + int'(v.total) + v.bursts));
        chk("busy_in_done", 64'(bus.busy), 64'd0);
        tick();
        chk("done_pulse_width", 64'(bus.layer_done), 64'd0);
        chk("busy_after_done", 64'(bus.busy), 64'd0);
        chk("scoreboard_empty", 64'(sbq.size()), 64'd0);
        bus.req = 4'b0000;
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_gnt"}, 64'(bus.gnt), 64'd0);
        chk({tag, "_wr_sel"}, 64'(bus.wr_sel), 64'd0);
        chk({tag, "_beat_idx"}, 64'(bus.beat_idx), 64'd0);
        chk({tag, "_wr_en"}, 64'(bus.wr_en), 64'd0);
        chk({tag, "_wr_addr"}, 64'(bus.wr_addr), 64'd0);
        chk({tag, "_burst_last"}, 64'(bus.burst_last), 64'd0);
        chk({tag, "_busy"}, 64'(bus.busy), 64'd0);
        chk({tag, "_layer_done"}, 64'(bus.layer_done), 64'd0);
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        m_lastg  = 3;
        vecs[0] = '{base: 32'h0000_2000, total: 32'd16, req: 4'b1111, spur: 1'b0, bursts: 4};
        vecs[1] = '{base: 32'h0000_0100, total: 32'd8,  req: 4'b0001, spur: 1'b0, bursts: 2};
        vecs[2] = '{base: 32'h0000_0040, total: 32'd6,  req: 4'b0100, spur: 1'b1, bursts: 2};
        vecs[3] = '{base: 32'hFFFF_FFFE, total: 32'd4,  req: 4'b1111, spur: 1'b0, bursts: 1};
        vecs[4] = '{base: 32'h0000_0080, total: 32'd0,  req: 4'b0001, spur: 1'b0, bursts: 0};
        vecs[5] = '{base: 32'h0000_0010, total: 32'd5,  req: 4'b1010, spur: 1'b0, bursts: 2};

        rst_n               = 1'b0;
        bus.start           = 1'b0;
        bus.abort           = 1'b0;
        bus.cfg_base_addr   = 32'd0;
        bus.cfg_total_words = 32'd0;
        bus.req             = 4'b0000;
        repeat (2) @(negedge clk);
        check_all_zero("reset");
        rst_n = 1'b1;
        tick();

        for (int i = 0; i < 6; i++) run_layer(vecs[i]);

        // Sparse requests: ARB waits with no request, grant follows req.
        for (int b = 0; b < 4; b++) push_exp(32'h300 + 32'(b), 3, b, b == 3);
        for (int b = 0; b < 4; b++) push_exp(32'h304 + 32'(b), 1, b, b == 3);
        bus.cfg_base_addr   = 32'h300;
        bus.cfg_total_words = 32'd8;
        bus.start           = 1'b1;
        tick();
        bus.start = 1'b0;
        for (int k = 0; k < 3; k++) begin
            chk("sparse_wait_wr_en", 64'(bus.wr_en), 64'd0);
            chk("sparse_wait_busy", 64'(bus.busy), 64'd1);
            tick();
        end
        bus.req = 4'b1000;
        for (int k = 0; k < 10 && !(bus.wr_en === 1'b1 && bus.burst_last === 1'b1); k++) tick();
        chk("sparse_first_last", 64'(bus.burst_last), 64'd1);
        bus.req = 4'b0000;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("sparse_gap_wr_en", 64'(bus.wr_en), 64'd0);
        end
        bus.req = 4'b0010;
        for (int k = 0; k < 20 && bus.layer_done !== 1'b1; k++) tick();
        chk("sparse_layer_done", 64'(bus.layer_done), 64'd1);
        bus.req = 4'b0000;
        tick();
        chk("sparse_scoreboard_empty", 64'(sbq.size()), 64'd0);
        m_lastg = 1;

        // Abort on beat 2 of the first burst, then restart.
        for (int b = 0; b < 3; b++) push_exp(32'h500 + 32'(b), 0, b, 1'b0);
        bus.cfg_base_addr   = 32'h500;
        bus.cfg_total_words = 32'd8;
        bus.req             = 4'b0001;
        bus.start           = 1'b1;
        tick();
        bus.start = 1'b0;
        for (int k = 0; k < 10 && !(bus.wr_en === 1'b1 && bus.beat_idx === 2'd2); k++) tick();
        chk("abort_at_beat", 64'(bus.beat_idx), 64'd2);
        bus.abort = 1'b1;
        tick();
        bus.abort = 1'b0;
        chk("abort_wr_en", 64'(bus.wr_en), 64'd0);
        chk("abort_busy", 64'(bus.busy), 64'd0);
        chk("abort_layer_done", 64'(bus.layer_done), 64'd0);
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("abort_no_done", 64'(bus.layer_done), 64'd0);
        end
        m_lastg = 0;
        run_layer('{base: 32'h0, total: 32'd4, req: 4'b0001, spur: 1'b0, bursts: 1});

        // Abort wins over start in the same cycle.
        bus.cfg_total_words = 32'd4;
        bus.start           = 1'b1;
        bus.abort           = 1'b1;
        tick();
        bus.start = 1'b0;
        bus.abort = 1'b0;
        chk("abort_over_start_busy", 64'(bus.busy), 64'd0);
        tick();
        chk("abort_over_start_wr_en", 64'(bus.wr_en), 64'd0);

        // Asynchronous reset mid-burst.
        for (int b = 0; b < 2; b++) push_exp(32'h700 + 32'(b), 0, b, 1'b0);
        bus.cfg_base_addr   = 32'h700;
        bus.cfg_total_words = 32'd8;
        bus.req             = 4'b0001;
        bus.start           = 1'b1;
        tick();
        bus.start = 1'b0;
        for (int k = 0; k < 10 && !(bus.wr_en === 1'b1 && bus.beat_idx === 2'd1); k++) tick();
        chk("reset_at_beat", 64'(bus.beat_idx), 64'd1);
        rst_n = 1'b0;
        #1;
        check_all_zero("midburst_reset");
        bus.req = 4'b0000;
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        chk("post_reset_busy", 64'(bus.busy), 64'd0);
        chk("post_reset_scoreboard", 64'(sbq.size()), 64'd0);
        m_lastg = 3;
        run_layer('{base: 32'h900, total: 32'd8, req: 4'b1111, spur: 1'b0, bursts: 2});

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
